// File: rtl/lane_enc_pkg.sv
// rtl/lane_enc_pkg.sv - shared constants and helpers for the lane block encoder
//
// Purpose: sync header codes, 66-bit block geometry and field offsets used by
//          lane_block_encoder and lane_block_packer.
// Ports:   none (package).

package lane_enc_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  localparam int BLOCK_W     = 66;
  localparam int HDR_W       = 2;
  localparam int PAYLOAD_W   = 64;
  localparam int HDR_LSB     = 0;
  localparam int PAYLOAD_LSB = 2;

  // Header for a block whose byte-0 data_os value was os.
  function automatic logic [1:0] sync_hdr(input logic os);
    return os ? SYNC_DATA : SYNC_OS;
  endfunction

endpackage

// File: rtl/lane_block_packer.sv
// rtl/lane_block_packer.sv - per-lane byte accumulator and 66-bit block register
//
// Purpose: collects one lane's bytes into a 64-bit payload by byte index and
//          publishes {payload, header} into the block register on load.
// Ports:
//   clk        in   block clock
//   rst        in   synchronous active-low reset
//   clear      in   discard accumulator and block register (enable drop)
//   wr_en      in   write byte_in at wr_idx this edge
//   wr_idx     in   payload byte index 0..7
//   byte_in    in   lane byte
//   load       in   copy the assembled block (including this edge's byte)
//   hdr        in   2-bit sync header for the block being loaded
//   block_out  out  registered block, [1:0] header, [65:2] payload

module lane_block_packer
  import lane_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [7:0]         byte_in,
  input  logic               load,
  input  logic [HDR_W-1:0]   hdr,
  output logic [BLOCK_W-1:0] block_out
);

  logic [PAYLOAD_W-1:0] acc;
  logic [PAYLOAD_W-1:0] acc_next;

  // The last byte lands on the same edge as the load, so the output register
  // is fed from the merged view rather than the stored accumulator.
  always_comb begin
    acc_next = acc;
    if (wr_en) begin
      acc_next[{wr_idx, 3'b000} +: 8] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      acc       <= '0;
      block_out <= '0;
    end else begin
      acc <= acc_next;
      if (load) begin
        block_out[PAYLOAD_LSB +: PAYLOAD_W] <= acc_next;
        block_out[HDR_LSB +: HDR_W]         <= hdr;
      end
    end
  end

endmodule

// File: rtl/lane_block_encoder.sv
// rtl/lane_block_encoder.sv - two-lane 64b/66b block packer with sync header
//
// Purpose: packs one byte per lane per cycle into 66-bit blocks, strobes
//          block_valid once per completed block pair, flags header changes.
// Ports:
//   clk               in   block clock
//   rst               in   synchronous active-low reset
//   enable_enc        in   low discards all state (like reset)
//   data_os           in   1 = transport data, 0 = ordered set
//   lane_0_tx_in      in   lane 0 byte
//   lane_1_tx_in      in   lane 1 byte
//   lane_0_block_out  out  lane 0 block, [1:0] header, [65:2] payload
//   lane_1_block_out  out  lane 1 block, same layout
//   block_valid       out  one-cycle strobe, both blocks are new
//   os_err            out  sticky, data_os changed inside a block

module lane_block_encoder
  import lane_enc_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_enc,
  input  logic               data_os,
  input  logic [7:0]         lane_0_tx_in,
  input  logic [7:0]         lane_1_tx_in,
  output logic [BLOCK_W-1:0] lane_0_block_out,
  output logic [BLOCK_W-1:0] lane_1_block_out,
  output logic               block_valid,
  output logic               os_err
);

  localparam logic [2:0] CNT_LAST = 3'(BYTES_PER_BLOCK - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]       state;
  logic [2:0]       counter;
  logic             hdr_os;
  logic             first_byte;
  logic             last_byte;
  logic             load;
  logic [HDR_W-1:0] hdr;

  // Counter is forced to 0 whenever the encoder is idle, so the IDLE->FILL
  // edge and every wrap both land on byte 0.
  assign first_byte = (state == ST_IDLE) || (counter == 3'd0);
  assign last_byte  = (counter == CNT_LAST);
  assign load       = enable_enc && last_byte;
  assign hdr        = sync_hdr(hdr_os);

  always_ff @(posedge clk) begin
    if (!rst || !enable_enc) begin
      state       <= ST_IDLE;
      counter     <= 3'd0;
      hdr_os      <= 1'b0;
      os_err      <= 1'b0;
      block_valid <= 1'b0;
    end else begin
      state       <= ST_FILL;
      counter     <= counter + 3'd1;
      block_valid <= last_byte;
      if (first_byte) begin
        hdr_os <= data_os;
      end else if (data_os != hdr_os) begin
        os_err <= 1'b1;
      end
    end
  end

  lane_block_packer u_lane_0 (
    .clk       (clk),
    .rst       (rst),
    .clear     (!enable_enc),
    .wr_en     (enable_enc),
    .wr_idx    (counter),
    .byte_in   (lane_0_tx_in),
    .load      (load),
    .hdr       (hdr),
    .block_out (lane_0_block_out)
  );

  lane_block_packer u_lane_1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (!enable_enc),
    .wr_en     (enable_enc),
    .wr_idx    (counter),
    .byte_in   (lane_1_tx_in),
    .load      (load),
    .hdr       (hdr),
    .block_out (lane_1_block_out)
  );

endmodule

// File: tb/tb_lane_block_encoder.sv
// tb/tb_lane_block_encoder.sv - self-checking bench for lane_block_encoder

module tb_lane_block_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_enc;
  logic        data_os;
  logic [7:0]  lane_0_tx_in;
  logic [7:0]  lane_1_tx_in;
  logic [65:0] lane_0_block_out;
  logic [65:0] lane_1_block_out;
  logic        block_valid;
  logic        os_err;

  int total = 0;
  int bad   = 0;

  lane_block_encoder #(.BYTES_PER_BLOCK(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_enc       (enable_enc),
    .data_os          (data_os),
    .lane_0_tx_in     (lane_0_tx_in),
    .lane_1_tx_in     (lane_1_tx_in),
    .lane_0_block_out (lane_0_block_out),
    .lane_1_block_out (lane_1_block_out),
    .block_valid      (block_valid),
    .os_err           (os_err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes received since the block started, as queues.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic        m_hdr_os = 1'b0;
  logic        m_err    = 1'b0;
  logic        m_valid  = 1'b0;
  logic [65:0] m_l0     = '0;
  logic [65:0] m_l1     = '0;

  task automatic model_edge();
    if (!rst || !enable_enc) begin
      q0.delete(); q1.delete();
      m_err = 0; m_valid = 0; m_l0 = '0; m_l1 = '0; m_hdr_os = 0;
    end else begin
      if (q0.size() == 0) m_hdr_os = data_os;
      else if (data_os != m_hdr_os) m_err = 1;
      q0.push_back(lane_0_tx_in);
      q1.push_back(lane_1_tx_in);
      m_valid = 0;
      if (q0.size() == 8) begin
        m_l0 = '0; m_l1 = '0;
        for (int k = 0; k < 8; k++) begin
          m_l0 = m_l0 | (66'(q0[k]) << (8 * k + 2));
          m_l1 = m_l1 | (66'(q1[k]) << (8 * k + 2));
        end
        m_l0 = m_l0 | (m_hdr_os ? 66'd2 : 66'd1);
        m_l1 = m_l1 | (m_hdr_os ? 66'd2 : 66'd1);
        m_valid = 1;
        q0.delete(); q1.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs (called at negedge), clock one edge, sample at next negedge.
  task automatic step(input logic r, input logic en, input logic dos,
                      input logic [7:0] b0, input logic [7:0] b1);
    rst = r; enable_enc = en; data_os = dos;
    lane_0_tx_in = b0; lane_1_tx_in = b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic        en;
    logic        dos;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        exp_valid;
    logic [65:0] exp_l0;
    logic [65:0] exp_l1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst = 0; enable_enc = 0; data_os = 0; lane_0_tx_in = 0; lane_1_tx_in = 0;
    @(negedge clk);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      step(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      chk("rst_valid", 66'(block_valid), 66'd0);
      chk("rst_l0", lane_0_block_out, 66'd0);
      chk("rst_l1", lane_1_block_out, 66'd0);
      chk("rst_err", 66'(os_err), 66'd0);
    end

    // Data block table
    for (int i = 0; i < 8; i++) begin
      vecs[i].en = 1; vecs[i].dos = 1;
      vecs[i].b0 = 8'(i); vecs[i].b1 = 8'(8'h10 + i);
      vecs[i].exp_valid = (i == 7);
      vecs[i].exp_l0 = (i == 7) ? {64'h0706050403020100, 2'b10} : 66'd0;
      vecs[i].exp_l1 = (i == 7) ? {64'h1716151413121110, 2'b10} : 66'd0;
    end
    vecs[8].en = 0; vecs[8].dos = 1; vecs[8].b0 = 8'hff; vecs[8].b1 = 8'hff;
    vecs[8].exp_valid = 0; vecs[8].exp_l0 = '0; vecs[8].exp_l1 = '0;
    for (int i = 0; i < 9; i++) begin
      step(1, vecs[i].en, vecs[i].dos, vecs[i].b0, vecs[i].b1);
      chk($sformatf("tbl_valid[%0d]", i), 66'(block_valid), 66'(vecs[i].exp_valid));
      chk($sformatf("tbl_l0[%0d]", i), lane_0_block_out, vecs[i].exp_l0);
      chk($sformatf("tbl_l1[%0d]", i), lane_1_block_out, vecs[i].exp_l1);
    end

    // Ordered sets, 24 continuous cycles, 3 strobes 8 apart
    for (int i = 0; i < 24; i++) begin
      step(1, 1, 0, 8'(i), 8'(i) ^ 8'ha5);
      chk($sformatf("os_valid[%0d]", i), 66'(block_valid), 66'(i % 8 == 7));
      if (i % 8 == 7) begin
        chk("os_hdr0", 66'(lane_0_block_out[1:0]), 66'(2'b01));
        chk("os_hdr1", 66'(lane_1_block_out[1:0]), 66'(2'b01));
        chk("os_b7", 66'(lane_0_block_out[65:58]), 66'(i));
        chk("os_b0", 66'(lane_1_block_out[9:2]), 66'((i - 7) ^ 8'ha5));
      end
      chk("os_err0", 66'(os_err), 66'd0);
    end

    // Mid-block enable drop after byte 4 (outputs still hold last OS block)
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 8'h40 + 8'(i), 8'h50 + 8'(i));
      chk("drop_novalid", 66'(block_valid), 66'd0);
    end
    step(1, 0, 1, 8'h00, 8'h00);
    chk("drop_valid", 66'(block_valid), 66'd0);
    chk("drop_l0", lane_0_block_out, 66'd0);
    chk("drop_l1", lane_1_block_out, 66'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 8'h60 + 8'(i), 8'h70 + 8'(i));
      chk($sformatf("reen_valid[%0d]", i), 66'(block_valid), 66'(i == 7));
    end
    chk("reen_l0", lane_0_block_out, {64'h6766656463626160, 2'b10});
    chk("reen_l1", lane_1_block_out, {64'h7776757473727170, 2'b10});
    step(1, 0, 0, 8'h00, 8'h00);

    // Header mismatch: data_os 1 at byte 0, 0 at byte 3
    for (int i = 0; i < 8; i++) begin
      step(1, 1, (i != 3), 8'(i), 8'(i));
      chk($sformatf("mm_err[%0d]", i), 66'(os_err), 66'(i >= 3));
    end
    chk("mm_valid", 66'(block_valid), 66'd1);
    chk("mm_hdr", 66'(lane_0_block_out[1:0]), 66'(2'b10));
    step(1, 1, 1, 8'h00, 8'h00);
    chk("mm_sticky", 66'(os_err), 66'd1);
    step(1, 0, 1, 8'h00, 8'h00);
    chk("mm_clear", 66'(os_err), 66'd0);

    // Reset mid-block at byte 5 after one full block
    for (int i = 0; i < 13; i++) step(1, 1, 1, 8'(8'h80 + i), 8'(8'h90 + i));
    step(0, 1, 1, 8'haa, 8'hbb);
    chk("rmid_valid", 66'(block_valid), 66'd0);
    chk("rmid_l0", lane_0_block_out, 66'd0);
    chk("rmid_l1", lane_1_block_out, 66'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 8'(8'hc0 + i), 8'(8'hd0 + i));
      chk($sformatf("rrel_valid[%0d]", i), 66'(block_valid), 66'(i == 7));
    end
    chk("rrel_l0", lane_0_block_out, {64'hc7c6c5c4c3c2c1c0, 2'b10});

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic r, en, dos;
      r   = ($urandom_range(99) >= 3);
      en  = ($urandom_range(99) >= 6);
      dos = ($urandom_range(99) < 10) ? ~data_os : data_os;
      step(r, en, dos, 8'($urandom), 8'($urandom));
      chk("rnd_valid", 66'(block_valid), 66'(m_valid));
      chk("rnd_err", 66'(os_err), 66'(m_err));
      chk("rnd_l0", lane_0_block_out, m_l0);
      chk("rnd_l1", lane_1_block_out, m_l1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
